poly_mau_seq: RTL and testbench

Sequencer that streams one full polynomial (N coefficients) from coefficient memory through the polynomial MAU and writes the results back. It latches the operation configuration on `start`, then issues reads and MAU enables, and tracks in-flight coefficients through the fixed-latency MAU pipeline. It generates the write-back address and strobe, and pulses `done` when the last result is written. It sits between the top-level crypto-core FSM and the MAU/coefficient-RAM pair.

---
 rtl/poly_pkg.sv | 37 +++
 rtl/poly_seq_dline.sv | 56 +++++
 rtl/poly_mau_seq.sv | 160 ++++++++++++++++
 tb/tb_poly_mau_seq.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/poly_pkg.sv
// Shared definitions for the polynomial MAU sequencer: ALU mode codes,
// compress/decompose encodings and the sequencer FSM state type.
package poly_pkg;

    typedef enum logic [3:0] {
        ALU_NTT256  = 4'd0,
        ALU_NTT512  = 4'd1,
        ALU_INTT256 = 4'd2,
        ALU_INTT512 = 4'd3,
        ALU_PWM     = 4'd4,
        ALU_PWM2    = 4'd5,
        ALU_PSUB    = 4'd6,
        ALU_PADD    = 4'd7,
        ALU_P2R     = 4'd8,
        ALU_DECPS   = 4'd9,
        ALU_MKHT    = 4'd10,
        ALU_USHT    = 4'd11,
        ALU_DECSS   = 4'd12,
        ALU_CSS     = 4'd13
    } alu_mode_e;

    localparam logic [1:0] CMP_NONE       = 2'b00;
    localparam logic [1:0] CMP_COMPRESS   = 2'b01;
    localparam logic [1:0] CMP_DECOMPRESS = 2'b11;

    localparam logic [1:0] DCP_NONE = 2'b00;
    localparam logic [1:0] DCP_Q44  = 2'b01;
    localparam logic [1:0] DCP_Q16  = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } seq_state_e;

endpackage

// File: rtl/poly_seq_dline.sv
// {valid, addr} delay line of DEPTH stages. Flush kills every valid bit on
// the next edge; addresses keep shifting since they are meaningless when
// invalid.
module poly_seq_dline #(
    parameter int DEPTH = 4,
    parameter int AW    = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          flush,
    input  logic          in_valid,
    input  logic [AW-1:0] in_addr,
    output logic          out_valid,
    output logic [AW-1:0] out_addr
);

    logic          v_chain [DEPTH+1];
    logic [AW-1:0] a_chain [DEPTH+1];

    assign v_chain[0] = in_valid;
    assign a_chain[0] = in_addr;

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_stage
            logic          valid_q;
            logic          valid_d;
            logic [AW-1:0] addr_q;
            logic [AW-1:0] addr_d;

            // next value of this stage: previous stage, or invalid on flush
            always_comb begin
                valid_d = flush ? 1'b0 : v_chain[gi];
                addr_d  = a_chain[gi];
            end

            // stage register
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    valid_q <= 1'b0;
                    addr_q  <= '0;
                end else begin
                    valid_q <= valid_d;
                    addr_q  <= addr_d;
                end
            end

            assign v_chain[gi+1] = valid_q;
            assign a_chain[gi+1] = addr_q;
        end
    endgenerate

    assign out_valid = v_chain[DEPTH];
    assign out_addr  = a_chain[DEPTH];

endmodule

// File: rtl/poly_mau_seq.sv
// Streams one polynomial from coefficient RAM through the MAU and back.
// Reads are issued from the ISSUE state, aligned to the 1-cycle RAM read,
// then carried through a MAU_LAT-deep delay line whose tail is the write
// strobe. The FSM only waits for the write count to reach N.
module poly_mau_seq
    import poly_pkg::*;
#(
    parameter int N       = 256,
    parameter int AW      = 8,
    parameter int MAU_LAT = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic          cfg_kd_sel,
    input  logic [3:0]    cfg_alu_mode,
    input  logic [1:0]    cfg_compress,
    input  logic [1:0]    cfg_decompose,
    input  logic          stall,
    input  logic          abort,
    output logic          busy,
    output logic          done,
    output logic          rd_en,
    output logic [AW-1:0] rd_addr,
    output logic          mau_enable,
    output logic          mau_kd_sel,
    output logic [3:0]    mau_alu_mode,
    output logic [1:0]    mau_compress,
    output logic [1:0]    mau_decompose,
    output logic          wr_en,
    output logic [AW-1:0] wr_addr
);

    localparam logic [AW:0] CNT_LAST = (AW+1)'(N - 1);

    seq_state_e    state_q, state_d;
    logic [AW:0]   ic_q, ic_d;
    logic [AW:0]   wc_q, wc_d;
    logic          kd_q, kd_d;
    logic [3:0]    alu_q, alu_d;
    logic [1:0]    cmp_q, cmp_d;
    logic [1:0]    dcp_q, dcp_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic [AW-1:0] mau_addr;

    // a read goes out every non-stalled ISSUE cycle; stall withholds it in the same cycle
    assign rd_en   = (state_q == ST_ISSUE) && !stall;
    assign rd_addr = ic_q[AW-1:0];

    // align address with the 1-cycle RAM read so mau_enable marks valid data
    poly_seq_dline #(.DEPTH(1), .AW(AW)) u_rd_align (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (abort),
        .in_valid  (rd_en),
        .in_addr   (rd_addr),
        .out_valid (mau_enable),
        .out_addr  (mau_addr)
    );

    // in-flight tracking across the MAU pipeline; the tail is the write-back
    poly_seq_dline #(.DEPTH(MAU_LAT), .AW(AW)) u_mau_lat (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (abort),
        .in_valid  (mau_enable),
        .in_addr   (mau_addr),
        .out_valid (wr_en),
        .out_addr  (wr_addr)
    );

    // next-state, counter and config-latch logic; abort overrides everything
    always_comb begin
        state_d = state_q;
        ic_d    = ic_q;
        wc_d    = wc_q;
        kd_d    = kd_q;
        alu_d   = alu_q;
        cmp_d   = cmp_q;
        dcp_d   = dcp_q;

        if (wr_en) begin
            wc_d = wc_q + 1'b1;
        end

        case (state_q)
            ST_IDLE: begin
                if (start && !abort) begin
                    kd_d    = cfg_kd_sel;
                    alu_d   = cfg_alu_mode;
                    cmp_d   = cfg_compress;
                    dcp_d   = cfg_decompose;
                    ic_d    = '0;
                    wc_d    = '0;
                    state_d = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (rd_en) begin
                    ic_d = ic_q + 1'b1;
                    if (ic_q == CNT_LAST) begin
                        state_d = ST_DRAIN;
                    end
                end
            end
            ST_DRAIN: begin
                if (wr_en && (wc_q == CNT_LAST)) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (abort) begin
            state_d = ST_IDLE;
        end

        busy_d = (state_d == ST_ISSUE) || (state_d == ST_DRAIN);
        done_d = (state_d == ST_DONE);
    end

    // FSM state, counters, latched config and registered status outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            ic_q    <= '0;
            wc_q    <= '0;
            kd_q    <= 1'b0;
            alu_q   <= '0;
            cmp_q   <= '0;
            dcp_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ic_q    <= ic_d;
            wc_q    <= wc_d;
            kd_q    <= kd_d;
            alu_q   <= alu_d;
            cmp_q   <= cmp_d;
            dcp_q   <= dcp_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign busy          = busy_q;
    assign done          = done_q;
    assign mau_kd_sel    = kd_q;
    assign mau_alu_mode  = alu_q;
    assign mau_compress  = cmp_q;
    assign mau_decompose = dcp_q;

endmodule

// File: tb/tb_poly_mau_seq.sv
// Bench for poly_mau_seq: randomized cfg/stall stimulus checked every cycle
// against a timing-rule model (issue cycles, scheduled MAU and write events).
module tb_poly_mau_seq;
    import poly_pkg::*;

    localparam int N   = 256;
    localparam int AW  = 8;
    localparam int LAT = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic          cfg_kd_sel = 1'b0;
    logic [3:0]    cfg_alu_mode = '0;
    logic [1:0]    cfg_compress = '0;
    logic [1:0]    cfg_decompose = '0;
    logic          stall = 1'b0;
    logic          abort = 1'b0;
    logic          busy, done, rd_en, mau_enable, wr_en, mau_kd_sel;
    logic [AW-1:0] rd_addr, wr_addr;
    logic [3:0]    mau_alu_mode;
    logic [1:0]    mau_compress, mau_decompose;

    always #5 clk = ~clk;

    poly_mau_seq #(.N(N), .AW(AW), .MAU_LAT(LAT)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .start         (start),
        .cfg_kd_sel    (cfg_kd_sel),
        .cfg_alu_mode  (cfg_alu_mode),
        .cfg_compress  (cfg_compress),
        .cfg_decompose (cfg_decompose),
        .stall         (stall),
        .abort         (abort),
        .busy          (busy),
        .done          (done),
        .rd_en         (rd_en),
        .rd_addr       (rd_addr),
        .mau_enable    (mau_enable),
        .mau_kd_sel    (mau_kd_sel),
        .mau_alu_mode  (mau_alu_mode),
        .mau_compress  (mau_compress),
        .mau_decompose (mau_decompose),
        .wr_en         (wr_en),
        .wr_addr       (wr_addr)
    );

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;

    typedef struct {
        int due;
        int addr;
    } ent_t;

    ent_t       mau_q[$];
    ent_t       wr_q[$];
    bit         m_run;
    int         m_issued;
    int         m_done_cycle;
    logic       m_kd;
    logic [3:0] m_alu;
    logic [1:0] m_cmp;
    logic [1:0] m_dcp;
    bit         obs_done;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=%0h expected=%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic model_reset();
        m_run = 1'b0;
        m_issued = 0;
        m_done_cycle = -1;
        m_kd = 1'b0;
        m_alu = '0;
        m_cmp = '0;
        m_dcp = '0;
        mau_q.delete();
        wr_q.delete();
    endtask

    // one clock cycle: drive inputs, predict, sample at negedge, advance model
    task automatic step(input bit st, input bit ab, input bit sl, input int cfg_sel);
        bit   exp_rd, exp_mau, exp_wr, exp_done;
        int   exp_ra, exp_wa;
        ent_t e;
        @(posedge clk);
        #1;
        cyc++;
        start = st;
        abort = ab;
        stall = sl;
        cfg_kd_sel    = 1'($urandom_range(1));
        cfg_alu_mode  = 4'($urandom_range(15));
        cfg_compress  = 2'($urandom_range(3));
        cfg_decompose = 2'($urandom_range(3));
        if (st && cfg_sel == 1) cfg_alu_mode = ALU_PADD;
        if (st && cfg_sel == 2) begin
            cfg_decompose = DCP_Q44;
            cfg_kd_sel = 1'b1;
        end

        exp_rd = m_run && (m_issued < N) && !sl;
        exp_ra = m_issued;
        exp_mau = 1'b0;
        exp_wr = 1'b0;
        exp_wa = 0;
        if (mau_q.size() > 0 && mau_q[0].due == cyc) begin
            exp_mau = 1'b1;
            void'(mau_q.pop_front());
        end
        if (wr_q.size() > 0 && wr_q[0].due == cyc) begin
            exp_wr = 1'b1;
            exp_wa = wr_q[0].addr;
            void'(wr_q.pop_front());
        end
        if (exp_rd) begin
            e.addr = m_issued;
            e.due = cyc + 1;
            mau_q.push_back(e);
            e.due = cyc + 1 + LAT;
            wr_q.push_back(e);
            m_issued++;
            if (m_issued == N) m_done_cycle = cyc + 2 + LAT;
        end
        exp_done = m_run && (cyc == m_done_cycle);

        @(negedge clk);
        check_eq("rd_en", 32'(rd_en), 32'(exp_rd));
        if (exp_rd) check_eq("rd_addr", 32'(rd_addr), exp_ra);
        check_eq("mau_enable", 32'(mau_enable), 32'(exp_mau));
        check_eq("wr_en", 32'(wr_en), 32'(exp_wr));
        if (exp_wr) check_eq("wr_addr", 32'(wr_addr), exp_wa);
        check_eq("busy", 32'(busy), 32'(m_run && !exp_done));
        check_eq("done", 32'(done), 32'(exp_done));
        check_eq("mau_kd_sel", 32'(mau_kd_sel), 32'(m_kd));
        check_eq("mau_alu_mode", 32'(mau_alu_mode), 32'(m_alu));
        check_eq("mau_compress", 32'(mau_compress), 32'(m_cmp));
        check_eq("mau_decompose", 32'(mau_decompose), 32'(m_dcp));
        obs_done = done;

        if (rst_n) begin
            if (ab) begin
                m_run = 1'b0;
                mau_q.delete();
                wr_q.delete();
            end else if (m_run) begin
                if (exp_done) m_run = 1'b0;
            end else if (st) begin
                m_run = 1'b1;
                m_issued = 0;
                m_done_cycle = -1;
                m_kd = cfg_kd_sel;
                m_alu = cfg_alu_mode;
                m_cmp = cfg_compress;
                m_dcp = cfg_decompose;
            end
        end
    endtask

    // one scenario; rel cycle 0 carries the start pulse
    task automatic run_scn(input string name, input int stall_lo, input int stall_hi,
                           input int repulse, input int abort_at, input int restart_at,
                           input int pct, input int cfg_sel, input int exp_lat, input int budget);
        int done_at = -1;
        int ndone = 0;
        for (int r = 0; r < budget; r++) begin
            bit st, ab, sl;
            st = (r == 0) || (r == repulse) || (r == restart_at);
            ab = (r == abort_at);
            sl = (r >= stall_lo && r <= stall_hi) || (int'($urandom_range(99)) < pct);
            step(st, ab, sl, cfg_sel);
            if (obs_done) begin
                ndone++;
                if (done_at < 0) done_at = r;
            end
            if (exp_lat < 0 && done_at >= 0) break;
        end
        if (exp_lat >= 0) check_eq({name, "_done_cycle"}, done_at, exp_lat);
        else check_eq({name, "_done_seen"}, 32'(done_at >= 0), 32'd1);
        check_eq({name, "_done_count"}, ndone, 1);
        $display("run %s: done at rel cycle %0d, %0d done pulse(s)", name, done_at, ndone);
    endtask

    task automatic check_all_zero(input string tag);
        check_eq({tag, "_busy"}, 32'(busy), 0);
        check_eq({tag, "_done"}, 32'(done), 0);
        check_eq({tag, "_rd_en"}, 32'(rd_en), 0);
        check_eq({tag, "_rd_addr"}, 32'(rd_addr), 0);
        check_eq({tag, "_mau_enable"}, 32'(mau_enable), 0);
        check_eq({tag, "_wr_en"}, 32'(wr_en), 0);
        check_eq({tag, "_wr_addr"}, 32'(wr_addr), 0);
        check_eq({tag, "_cfg"}, {mau_kd_sel, mau_alu_mode, mau_compress, mau_decompose}, 0);
    endtask

    initial begin
        model_reset();
        repeat (2) @(negedge clk);
        check_all_zero("reset");
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b0, 0);

        run_scn("padd_nostall", -1, -1, -1, -1, -1, 0, 1, N + 2 + LAT, N + 2 + LAT + 8);
        run_scn("stall_10_14", 10, 14, -1, -1, -1, 0, 0, N + 2 + LAT + 5, N + 2 + LAT + 13);
        run_scn("repulse_100", -1, -1, 100, -1, -1, 0, 0, N + 2 + LAT, N + 2 + LAT + 8);
        run_scn("abort_50", -1, -1, -1, 50, 52, 0, 0, 52 + N + 2 + LAT, 52 + N + 2 + LAT + 8);
        run_scn("cfg_hold", -1, -1, -1, -1, -1, 20, 2, -1, 1500);
        check_eq("cfg_hold_decompose", 32'(mau_decompose), 32'(DCP_Q44));
        check_eq("cfg_hold_kd_sel", 32'(mau_kd_sel), 1);

        // asynchronous reset in rel cycle 30 of a run
        for (int r = 0; r < 30; r++) step(r == 0, 1'b0, 1'b0, 0);
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1 check_all_zero("async_rst");
        model_reset();
        for (int i = 0; i < 2; i++) step(1'b0, 1'b0, 1'b0, 0);
        rst_n = 1'b1;
        for (int i = 0; i < 20; i++) step(1'b0, 1'b0, $urandom_range(1) == 1, 0);
        $display("run async_rst: outputs cleared, idle after release");

        for (int k = 0; k < 2; k++) begin
            run_scn("random_stall", -1, -1, -1, -1, -1, 40, 0, -1, 1500);
            for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 1'b0, 0);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
